mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
- Sequences one Montgomery multiplier core through a left-to-right binary modular exponentiation (square-and-multiply).
- Sits between the rsa top-level command FSM and a single montgomery instance.
- Issues one operation at a time over a start/done handshake and drives operand-select codes and result-register write strobes.
- Holds no 1024-bit operands itself; the top-level muxes and registers the operands from `mm_op`, `a_we` and `xt_we`.

Parameters:
- E_W, 1024, exponent register width in bits.
- LEN_W, 11, width of the exponent bit-length field; must satisfy 2^LEN_W > E_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset, sampled on rising clk.
- start  in  1  single-cycle request; accepted only in IDLE.
- exp  in  E_W  exponent; captured on accepted start.
- exp_len  in  LEN_W  number of exponent bits to scan, MSB first from bit exp_len-1; captured on accepted start.
- mm_done  in  1  single-cycle completion pulse from the Montgomery core.
- mm_start  out  1  single-cycle start pulse to the core.
- mm_op  out  2  operation select: 0 TOMONT (X~=MM(X,R2N)), 1 SQ (A=MM(A,A)), 2 MUL (A=MM(A,X~)), 3 FROMMONT (A=MM(A,1)).
- a_we  out  1  write strobe for the A register; high in the mm_done cycle of op 1, 2 or 3.
- xt_we  out  1  write strobe for the X~ register; high in the mm_done cycle of op 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the full exponentiation completes.
- bit_idx  out  LEN_W  index of the exponent bit currently being processed, for debug.

Behaviour:
- Reset:
  - resetn=0 at a clk edge forces state IDLE.
  - All outputs 0: mm_start, mm_op, a_we, xt_we, busy, done, bit_idx.
  - Internal exponent copy, length and the mul_pending flag cleared.
- Reset mid-operation aborts immediately. No mm_start is issued afterwards. A late mm_done is ignored because it arrives in IDLE.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - On start=1: latch exp and exp_len, set op=TOMONT, set bit_idx=exp_len-1, go to ISSUE.
  - With exp_len=0, bit_idx is don't-care.
- ISSUE:
  - Lasts exactly one cycle.
  - mm_start=1 for that cycle; mm_op is valid and held stable through the following WAIT.
  - Next state is always WAIT.
- WAIT:
  - Hold until mm_done=1. In the mm_done cycle, pulse the strobe for the current op (xt_we for op 0, a_we otherwise).
  - Next op on mm_done:
    - After TOMONT: SQ if exp_len>0, else FROMMONT.
    - After SQ: if bit[bit_idx]=1, MUL; else advance.
    - After MUL: advance.
    - "advance": if bit_idx==0, next op is FROMMONT; else decrement bit_idx and next op is SQ.
    - After FROMMONT: go to FINISH.
  - Every other transition out of WAIT returns to ISSUE.
- FINISH: done=1 for one cycle, then IDLE.
- mm_done arriving in IDLE, ISSUE or FINISH is ignored: no strobes, no state change.
- start while busy=1 is ignored, and exp/exp_len are not re-latched.
- exp_len > E_W is clamped to E_W at capture.
- Operation count per run = 2 + exp_len + popcount(exp[exp_len-1:0]).
- Controller overhead: 1 ISSUE cycle per op, plus 1 IDLE→ISSUE cycle and 1 FINISH cycle per run.
- The core must not pulse mm_done in the same cycle as mm_start. Such a pulse is ignored per the rule above.

Optional Feature:
- Macro: MONT_EXP_PERF_EN.
- When defined, adds two outputs:
  - op_count (out, 16): number of mm_start pulses in the current or last run.
  - cyc_count (out, 32): clk cycles from the accepted start up to and including the done pulse.
- Both counters clear on an accepted start and on reset, hold after done, and saturate at all-ones.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- exp=0b1011, exp_len=4, core done 5 cycles after each mm_start → mm_op sequence 0,1,2,1,1,2,1,2,3 (9 ops); one xt_we then 8 a_we; done once; busy low the cycle after done.
- exp_len=0 → ops 0,3 only; done after the 2nd mm_done; bit_idx never decremented.
- exp=all-ones, E_W=1024, exp_len=1024 → 2050 ops; bit_idx counts 1023 down to 0; no extra SQ after bit 0.
- Spurious mm_done while in IDLE, and again during an ISSUE cycle → no a_we/xt_we, no state change; start pulsed mid-run is ignored.
- resetn=0 asserted while in WAIT of the 3rd op → next cycle IDLE with all outputs 0; a later mm_done produces nothing; a new start restarts from TOMONT.
- MONT_EXP_PERF_EN with exp=0b1011, exp_len=4, fixed 5-cycle core → op_count=9; cyc_count=1+9×6+1=56, checked against bench count.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply sequencer for one Montgomery core
// Optional macro MONT_EXP_PERF_EN adds op_count/cyc_count performance counters.
module mont_exp_ctrl #(
  parameter int E_W   = 1024,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [E_W-1:0]   exp,
  input  logic [LEN_W-1:0] exp_len,
  input  logic             mm_done,
  output logic             mm_start,
  output logic [1:0]       mm_op,
  output logic             a_we,
  output logic             xt_we,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx
`ifdef MONT_EXP_PERF_EN
  ,
  output logic [15:0]      op_count,
  output logic [31:0]      cyc_count
`endif
);

  localparam logic [1:0] OP_TOMONT   = 2'd0;
  localparam logic [1:0] OP_SQ       = 2'd1;
  localparam logic [1:0] OP_MUL      = 2'd2;
  localparam logic [1:0] OP_FROMMONT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t           state, state_n;
  logic [1:0]       op_q, op_n;
  logic [LEN_W-1:0] idx_q, idx_n;
  logic [E_W-1:0]   exp_q, exp_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] len_cap;
  logic [E_W-1:0]   bit_sel;
  logic             cur_bit;
  logic             advance;

  assign len_cap = (exp_len > LEN_W'(E_W)) ? LEN_W'(E_W) : exp_len;
  // One-hot mask rather than a direct select keeps out-of-range indices (exp_len=0) harmless.
  assign bit_sel = {{(E_W-1){1'b0}}, 1'b1} << idx_q;
  assign cur_bit = |(exp_q & bit_sel);

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    idx_n    = idx_q;
    exp_n    = exp_q;
    len_n    = len_q;
    mm_start = 1'b0;
    a_we     = 1'b0;
    xt_we    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    advance  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          exp_n   = exp;
          len_n   = len_cap;
          idx_n   = len_cap - LEN_W'(1);
          op_n    = OP_TOMONT;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mm_start = 1'b1;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        if (mm_done) begin
          xt_we   = (op_q == OP_TOMONT);
          a_we    = (op_q != OP_TOMONT);
          state_n = S_ISSUE;
          case (op_q)
            OP_TOMONT: op_n = (len_q != '0) ? OP_SQ : OP_FROMMONT;
            OP_SQ: begin
              if (cur_bit) op_n = OP_MUL;
              else         advance = 1'b1;
            end
            OP_MUL:  advance = 1'b1;
            default: state_n = S_FINISH;
          endcase
          if (advance) begin
            if (idx_q == '0) begin
              op_n = OP_FROMMONT;
            end else begin
              idx_n = idx_q - LEN_W'(1);
              op_n  = OP_SQ;
            end
          end
        end
      end
      default: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      op_q  <= OP_TOMONT;
      idx_q <= '0;
      exp_q <= '0;
      len_q <= '0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      idx_q <= idx_n;
      exp_q <= exp_n;
      len_q <= len_n;
    end
  end

  assign mm_op   = op_q;
  assign bit_idx = idx_q;

`ifdef MONT_EXP_PERF_EN
  // The accept cycle itself is the first counted cycle, hence the load of 1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_count  <= '0;
      cyc_count <= '0;
    end else if (state == S_IDLE && start) begin
      op_count  <= '0;
      cyc_count <= 32'd1;
    end else if (state != S_IDLE) begin
      if (cyc_count != '1) cyc_count <= cyc_count + 32'd1;
      if (mm_start && op_count != '1) op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - self-checking bench for mont_exp_ctrl with a latency-programmable core model
module tb_mont_exp_ctrl;
  localparam int E_W   = 1024;
  localparam int LEN_W = 11;
  localparam int LIMIT = 40000;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [E_W-1:0]   exp = '0;
  logic [LEN_W-1:0] exp_len = '0;
  logic             core_done = 1'b0;
  logic             spur_done = 1'b0;
  logic             mm_done;
  logic             mm_start;
  logic [1:0]       mm_op;
  logic             a_we;
  logic             xt_we;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bit_idx;
`ifdef MONT_EXP_PERF_EN
  logic [15:0]      op_count;
  logic [31:0]      cyc_count;
`endif

  assign mm_done = core_done | spur_done;

  mont_exp_ctrl #(.E_W(E_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .exp(exp), .exp_len(exp_len),
    .mm_done(mm_done), .mm_start(mm_start), .mm_op(mm_op), .a_we(a_we), .xt_we(xt_we),
    .busy(busy), .done(done), .bit_idx(bit_idx)
`ifdef MONT_EXP_PERF_EN
    , .op_count(op_count), .cyc_count(cyc_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Core model: mm_done is raised core_lat cycles after the cycle carrying mm_start.
  int core_lat = 5;
  bit core_rand = 1'b0;
  int core_cnt = 0;
  int lat_sum = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) core_done = 1'b1;
      end
      if (mm_start) begin
        int l;
        l = core_rand ? int'($urandom_range(1, 6)) : core_lat;
        core_cnt = l;
        lat_sum += l;
      end
    end
  end

  int  ops_seen[$];
  int  sq_idx_seen[$];
  int  start_idx_seen[$];
  int  strobes_seen[$];
  int  done_cnt = 0;
  int  cyc_meas = 0;
  int  hold_bad = 0;
  int  hold_op = 0;
  bit  counting = 1'b0;
  always @(negedge clk) begin
    if (counting) cyc_meas++;
    if (mm_start) begin
      ops_seen.push_back(int'(mm_op));
      start_idx_seen.push_back(int'(bit_idx));
      if (mm_op == 2'd1) sq_idx_seen.push_back(int'(bit_idx));
      hold_op = int'(mm_op);
    end else if (busy && !done && int'(mm_op) != hold_op) begin
      hold_bad++;
    end
    if (xt_we) strobes_seen.push_back(4 + int'(mm_op));
    if (a_we)  strobes_seen.push_back(8 + int'(mm_op));
    if (done) begin
      done_cnt++;
      counting = 1'b0;
    end
    if (start && !busy) begin
      counting = 1'b1;
      cyc_meas = 1;
    end
  end

  int exp_ops[$];
  int exp_sq[$];
  int exp_pop;

  task automatic build_model(input logic [E_W-1:0] e, input int len);
    int n;
    logic [E_W-1:0] sh;
    n = (len > E_W) ? E_W : len;
    exp_ops = {};
    exp_sq  = {};
    exp_pop = 0;
    exp_ops.push_back(0);
    for (int i = n - 1; i >= 0; i--) begin
      sh = e >> i;
      exp_ops.push_back(1);
      exp_sq.push_back(i);
      if (sh[0]) begin
        exp_ops.push_back(2);
        exp_pop++;
      end
    end
    exp_ops.push_back(3);
  endtask

  task automatic clear_mon();
    ops_seen = {};
    sq_idx_seen = {};
    start_idx_seen = {};
    strobes_seen = {};
    done_cnt = 0;
    hold_bad = 0;
    lat_sum = 0;
  endtask

  function automatic int diff_ops();
    if (ops_seen.size() != exp_ops.size()) return -2;
    foreach (exp_ops[i]) if (ops_seen[i] != exp_ops[i]) return i;
    return -1;
  endfunction

  function automatic int diff_sq();
    if (sq_idx_seen.size() != exp_sq.size()) return -2;
    foreach (exp_sq[i]) if (sq_idx_seen[i] != exp_sq[i]) return i;
    return -1;
  endfunction

  function automatic int diff_strobes();
    if (strobes_seen.size() != exp_ops.size()) return -2;
    foreach (exp_ops[i])
      if (strobes_seen[i] != ((exp_ops[i] == 0) ? 4 : 8) + exp_ops[i]) return i;
    return -1;
  endfunction

  // Entered and left at posedge+1.
  task automatic run_exp(input string name, input logic [E_W-1:0] e, input int len,
                         input bit mid_start, input bit spur_issue);
    int guard;
    int n;
    int r;
    int exp_cyc;
    n = (len > E_W) ? E_W : len;
    build_model(e, len);
    clear_mon();
    exp = e;
    exp_len = LEN_W'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < LIMIT) begin
      start = mid_start && (guard == 6);
      if (start) begin
        exp = ~e;
        exp_len = LEN_W'(5);
      end
      spur_done = spur_issue && mm_start && (ops_seen.size() == 2);
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    spur_done = 1'b0;
    vectors++;
    if (guard >= LIMIT) begin
      miscompares++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, LIMIT);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after_done: busy=%b done=%b want 0 0", name, busy, done);
    end
    r = diff_ops();
    vectors++;
    if (r != -1) begin
      miscompares++;
      $display("FAIL %s op_seq: diverges at %0d, got %0d ops want %0d", name, r, ops_seen.size(), exp_ops.size());
    end
    vectors++;
    if (ops_seen.size() != 2 + n + exp_pop) begin
      miscompares++;
      $display("FAIL %s op_total: got %0d want %0d", name, ops_seen.size(), 2 + n + exp_pop);
    end
    r = diff_sq();
    vectors++;
    if (r != -1) begin
      miscompares++;
      $display("FAIL %s sq_bit_idx: diverges at %0d, got %0d squares want %0d", name, r, sq_idx_seen.size(), exp_sq.size());
    end
    r = diff_strobes();
    vectors++;
    if (r != -1) begin
      miscompares++;
      $display("FAIL %s strobes: diverges at %0d, got %0d strobes want %0d", name, r, strobes_seen.size(), exp_ops.size());
    end
    vectors++;
    if (done_cnt != 1 || hold_bad != 0) begin
      miscompares++;
      $display("FAIL %s done_hold: done pulses %0d want 1, op changes in wait %0d want 0", name, done_cnt, hold_bad);
    end
    exp_cyc = 2 + exp_ops.size() + lat_sum;
    vectors++;
    if (cyc_meas != exp_cyc) begin
      miscompares++;
      $display("FAIL %s cycles: got %0d want %0d", name, cyc_meas, exp_cyc);
    end
`ifdef MONT_EXP_PERF_EN
    vectors++;
    if (int'(op_count) != exp_ops.size() || int'(cyc_count) != exp_cyc) begin
      miscompares++;
      $display("FAIL %s perf: op_count=%0d cyc_count=%0d want %0d %0d", name, op_count, cyc_count, exp_ops.size(), exp_cyc);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({mm_start, mm_op, a_we, xt_we, busy, done} !== 7'b0 || bit_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: start=%b op=%0d a_we=%b xt_we=%b busy=%b done=%b idx=%0d want all 0",
               mm_start, mm_op, a_we, xt_we, busy, done, bit_idx);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    core_rand = 1'b0;
    core_lat = 5;
    run_exp("directed_1011", E_W'(4'b1011), 4, 1'b0, 1'b0);
    vectors++;
    if (cyc_meas != 56 || ops_seen.size() != 9) begin
      miscompares++;
      $display("FAIL directed_totals: cycles=%0d ops=%0d want 56 9", cyc_meas, ops_seen.size());
    end
  endtask

  task automatic test_len_zero();
    int bad;
    logic [E_W-1:0] e;
    for (int w = 0; w < E_W / 32; w++) e[w*32 +: 32] = $urandom();
    core_rand = 1'b0;
    core_lat = 3;
    run_exp("len_zero", e, 0, 1'b0, 1'b0);
    bad = 0;
    foreach (start_idx_seen[i]) if (start_idx_seen[i] != start_idx_seen[0]) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL len_zero_idx: bit_idx changed %0d times want 0", bad);
    end
  endtask

  task automatic test_full();
    logic [E_W-1:0] e;
    core_rand = 1'b0;
    core_lat = 1;
    run_exp("full_ones", '1, E_W, 1'b0, 1'b0);
    for (int w = 0; w < E_W / 32; w++) e[w*32 +: 32] = $urandom();
    run_exp("len_clamp", e, 1500, 1'b0, 1'b0);
  endtask

  task automatic test_spurious();
    clear_mon();
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (strobes_seen.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL spur_idle: strobes=%0d busy=%b want 0 0", strobes_seen.size(), busy);
    end
    @(posedge clk); #1;
    core_rand = 1'b0;
    core_lat = 5;
    run_exp("spur_issue_mid_start", E_W'(4'b1011), 4, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int guard;
    int n_ops;
    int n_str;
    core_rand = 1'b0;
    core_lat = 5;
    clear_mon();
    exp = E_W'(8'b1101_0110);
    exp_len = LEN_W'(8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (ops_seen.size() < 3 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL reset_mid_reach: third op not issued, got %0d ops want 3", ops_seen.size());
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mm_start, mm_op, a_we, xt_we, busy, done} !== 7'b0 || bit_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: start=%b op=%0d a_we=%b xt_we=%b busy=%b done=%b idx=%0d want all 0",
               mm_start, mm_op, a_we, xt_we, busy, done, bit_idx);
    end
    n_ops = ops_seen.size();
    n_str = strobes_seen.size();
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (ops_seen.size() != n_ops || strobes_seen.size() != n_str || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: new ops=%0d new strobes=%0d busy=%b want 0 0 0",
               ops_seen.size() - n_ops, strobes_seen.size() - n_str, busy);
    end
    run_exp("restart_after_reset", E_W'(8'b1101_0110), 8, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [E_W-1:0] e;
    int len;
    core_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      for (int w = 0; w < E_W / 32; w++) e[w*32 +: 32] = $urandom();
      len = $urandom_range(0, 48);
      run_exp($sformatf("random_%0d", k), e, len, 1'($urandom_range(0, 1)), 1'b0);
    end
    core_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_len_zero();
    test_spurious();
    test_reset_mid();
    test_random();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
